// File: rtl/dense_layer_seq.sv
// dense_layer_seq: sequencer for one fully-connected int8 layer.
// Walks the input/weight/bias memories, drives an external combinational
// 16x16 signed multiplier with zero-point-shifted operands, accumulates the
// 32-bit products, then applies bias, optional ReLU and fixed-point
// requantization before writing one int8 activation per output neuron.
// Build option: define DENSE_SAT_EN to clamp results to [-128,127]; when it
// is undefined the result is the low byte of the 16-bit requantized value.
module dense_layer_seq #(
  parameter int IN_AW  = 10,
  parameter int OUT_AW = 10,
  parameter int W_AW   = 17
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [IN_AW-1:0]         i_n_in,
  input  logic [OUT_AW-1:0]        i_n_out,
  input  logic                     i_relu_en,
  input  logic [7:0]               i_input_zp,
  input  logic [7:0]               i_filter_zp,
  input  logic [7:0]               i_output_zp,
  input  logic [31:0]              i_quant_mult,
  input  logic [4:0]               i_quant_shift,
  output logic [IN_AW-1:0]         o_in_addr,
  input  logic [7:0]               i_in_data,
  output logic [W_AW-1:0]          o_w_addr,
  input  logic [7:0]               i_w_data,
  output logic [OUT_AW-1:0]        o_b_addr,
  input  logic [31:0]              i_b_data,
  output logic signed [15:0]       o_mul_a,
  output logic signed [15:0]       o_mul_b,
  input  logic signed [31:0]       i_mul_z,
  output logic                     o_out_we,
  output logic [OUT_AW-1:0]        o_out_addr,
  output logic [7:0]               o_out_data,
  output logic                     o_busy,
  output logic                     o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_DRAIN,
    S_BIAS,
    S_REQ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // Latched layer configuration.
  logic [IN_AW-1:0]  n_in_q;
  logic [OUT_AW-1:0] n_out_q;
  logic              relu_q;
  logic [7:0]        izp_q, fzp_q, ozp_q;
  logic [31:0]       mult_q;
  logic [4:0]        shift_q;

  // Walk counters: input index k, neuron index j, weight row base j*n_in.
  logic [IN_AW-1:0]  k_q;
  logic [OUT_AW-1:0] j_q;
  logic [W_AW-1:0]   base_q;
  logic [W_AW-1:0]   w_addr_q;

  // Pipeline bookkeeping: drain_q marks the second DRAIN cycle, rd_v_q marks
  // memory data valid (cycle after a MAC read), op_v_q marks operands valid.
  logic              drain_q;
  logic              rd_v_q;
  logic              op_v_q;

  logic signed [15:0] mul_a_q, mul_b_q;
  logic [31:0]        acc_q;
  logic [31:0]        r_q;
  logic [7:0]         out_q;

  logic              start_ok;
  logic              last_k;
  logic              last_j;
  logic [31:0]       bias_sum;
  logic [W_AW-1:0]   next_base;

  assign start_ok  = (state_q == S_IDLE) && i_start;
  assign last_k    = (k_q == n_in_q - IN_AW'(1));
  assign last_j    = (j_q == n_out_q - OUT_AW'(1));
  assign bias_sum  = acc_q + i_b_data;
  assign next_base = base_q + W_AW'(n_in_q);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: state_d gets its default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_start) state_d = S_LOAD;
      S_LOAD:  state_d = ((n_in_q == '0) || (n_out_q == '0)) ? S_DONE : S_MAC;
      S_MAC:   if (last_k) state_d = S_DRAIN;
      S_DRAIN: if (drain_q) state_d = S_BIAS;
      S_BIAS:  state_d = S_REQ;
      S_REQ:   state_d = S_WRITE;
      S_WRITE: state_d = last_j ? S_DONE : S_MAC;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Capture the layer configuration in the cycle the start is accepted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      n_in_q  <= '0;
      n_out_q <= '0;
      relu_q  <= 1'b0;
      izp_q   <= '0;
      fzp_q   <= '0;
      ozp_q   <= '0;
      mult_q  <= '0;
      shift_q <= '0;
    end else if (start_ok) begin
      n_in_q  <= i_n_in;
      n_out_q <= i_n_out;
      relu_q  <= i_relu_en;
      izp_q   <= i_input_zp;
      fzp_q   <= i_filter_zp;
      ozp_q   <= i_output_zp;
      mult_q  <= i_quant_mult;
      shift_q <= i_quant_shift;
    end
  end

  // Address walk: k steps through the inputs, the weight address tracks
  // base+k, and the row base advances by n_in per neuron (no multiplier).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      k_q      <= '0;
      j_q      <= '0;
      base_q   <= '0;
      w_addr_q <= '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          k_q      <= '0;
          j_q      <= '0;
          base_q   <= '0;
          w_addr_q <= '0;
        end
        S_MAC: begin
          k_q      <= k_q + IN_AW'(1);
          w_addr_q <= w_addr_q + W_AW'(1);
        end
        S_WRITE: begin
          k_q      <= '0;
          j_q      <= j_q + OUT_AW'(1);
          base_q   <= next_base;
          w_addr_q <= next_base;
        end
        default: ;
      endcase
    end
  end

  // Pipeline valid flags and the two-cycle drain counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      drain_q <= 1'b0;
      rd_v_q  <= 1'b0;
      op_v_q  <= 1'b0;
    end else begin
      drain_q <= (state_q == S_DRAIN) && !drain_q;
      rd_v_q  <= (state_q == S_MAC);
      op_v_q  <= rd_v_q;
    end
  end

  // Operand stage: zero-point-shifted operands, held between MAC bursts.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mul_a_q <= '0;
      mul_b_q <= '0;
    end else if (rd_v_q) begin
      mul_a_q <= {{8{i_in_data[7]}}, i_in_data} - {{8{izp_q[7]}}, izp_q};
      mul_b_q <= {{8{i_w_data[7]}}, i_w_data} - {{8{fzp_q[7]}}, fzp_q};
    end
  end

  // Accumulate stage, then bias add and ReLU; acc wraps modulo 2^32.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_q <= '0;
      r_q   <= '0;
    end else if ((state_q == S_LOAD) || (state_q == S_WRITE)) begin
      acc_q <= '0;
    end else if (op_v_q) begin
      acc_q <= acc_q + i_mul_z;
    end else if (state_q == S_BIAS) begin
      acc_q <= bias_sum;
      r_q   <= (relu_q && bias_sum[31]) ? '0 : bias_sum;
    end
  end

  // Requantization: round-to-nearest fixed-point multiply by mult/2^(31-shift),
  // then add the output zero point.
  logic [5:0]         ts;
  logic signed [63:0] r64, m64, rnd64, p64;
  logic [7:0]         out_d;
`ifdef DENSE_SAT_EN
  logic signed [15:0] y16;
`endif

  // Combinational requant datapath feeding the output register.
  always_comb begin
    ts    = 6'd31 - {1'b0, shift_q};
    r64   = {{32{r_q[31]}}, r_q};
    m64   = {{32{mult_q[31]}}, mult_q};
    rnd64 = (ts == 6'd0) ? 64'sd0 : (64'sd1 <<< (ts - 6'd1));
    p64   = r64 * m64 + rnd64;
`ifdef DENSE_SAT_EN
    y16   = 16'(p64 >>> ts) + {{8{ozp_q[7]}}, ozp_q};
    if (y16 > 16'sd127)        out_d = 8'h7F;
    else if (y16 < -16'sd128)  out_d = 8'h80;
    else                       out_d = y16[7:0];
`else
    out_d = 8'(p64 >>> ts) + ozp_q;
`endif
  end

  // Result register, loaded in REQ and presented during WRITE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                 out_q <= '0;
    else if (state_q == S_REQ) out_q <= out_d;
  end

  assign o_in_addr  = k_q;
  assign o_w_addr   = w_addr_q;
  assign o_b_addr   = j_q;
  assign o_mul_a    = mul_a_q;
  assign o_mul_b    = mul_b_q;
  assign o_out_we   = (state_q == S_WRITE);
  assign o_out_addr = j_q;
  assign o_out_data = out_q;
  assign o_busy     = (state_q != S_IDLE);
  assign o_done     = (state_q == S_DONE);

endmodule

// File: tb/tb_dense_layer_seq.sv
// tb_dense_layer_seq: table-driven bench for dense_layer_seq with behavioral
// synchronous memories and an exact combinational multiplier model.
module tb_dense_layer_seq;

  localparam int IN_AW  = 10;
  localparam int OUT_AW = 10;
  localparam int W_AW   = 17;

  logic                 i_clk = 1'b0;
  logic                 i_rst;
  logic                 i_start;
  logic [IN_AW-1:0]     i_n_in;
  logic [OUT_AW-1:0]    i_n_out;
  logic                 i_relu_en;
  logic [7:0]           i_input_zp, i_filter_zp, i_output_zp;
  logic [31:0]          i_quant_mult;
  logic [4:0]           i_quant_shift;
  logic [IN_AW-1:0]     o_in_addr;
  logic [7:0]           i_in_data;
  logic [W_AW-1:0]      o_w_addr;
  logic [7:0]           i_w_data;
  logic [OUT_AW-1:0]    o_b_addr;
  logic [31:0]          i_b_data;
  logic signed [15:0]   o_mul_a, o_mul_b;
  logic signed [31:0]   i_mul_z;
  logic                 o_out_we;
  logic [OUT_AW-1:0]    o_out_addr;
  logic [7:0]           o_out_data;
  logic                 o_busy;
  logic                 o_done;

  dense_layer_seq #(.IN_AW(IN_AW), .OUT_AW(OUT_AW), .W_AW(W_AW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_n_in(i_n_in), .i_n_out(i_n_out), .i_relu_en(i_relu_en),
    .i_input_zp(i_input_zp), .i_filter_zp(i_filter_zp), .i_output_zp(i_output_zp),
    .i_quant_mult(i_quant_mult), .i_quant_shift(i_quant_shift),
    .o_in_addr(o_in_addr), .i_in_data(i_in_data),
    .o_w_addr(o_w_addr), .i_w_data(i_w_data),
    .o_b_addr(o_b_addr), .i_b_data(i_b_data),
    .o_mul_a(o_mul_a), .o_mul_b(o_mul_b), .i_mul_z(i_mul_z),
    .o_out_we(o_out_we), .o_out_addr(o_out_addr), .o_out_data(o_out_data),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  // Memories with one-cycle synchronous read, and the exact multiplier.
  logic [7:0]  in_mem [0:1023];
  logic [7:0]  w_mem  [0:4095];
  logic [31:0] b_mem  [0:1023];

  always @(posedge i_clk) begin
    i_in_data <= in_mem[o_in_addr];
    i_w_data  <= w_mem[o_w_addr[11:0]];
    i_b_data  <= b_mem[o_b_addr];
  end

  assign i_mul_z = o_mul_a * o_mul_b;

  // Cycle counter and write/done monitor (sampled on the falling edge).
  int cyc = 0;
  int t0  = 0;
  int wr_addr_q[$];
  int wr_data_q[$];
  int wr_cyc_q[$];
  int done_cnt;
  int done_cyc;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (i_rst !== 1'b1) begin
      if (o_out_we === 1'b1) begin
        wr_addr_q.push_back(int'(o_out_addr));
        wr_data_q.push_back(int'(o_out_data));
        wr_cyc_q.push_back(cyc - t0);
      end
      if (o_done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc - t0;
      end
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int n_in;
    int n_out;
    int relu;
    int izp;
    int fzp;
    int ozp;
    int mult;
    int shift;
    int in_v[4];
    int w_v[8];
    int b_v[2];
    int exp_v[2];
    int exp_sat[2];
    int done_at;
    int first_wr;
  } vec_t;

  vec_t vecs[9];

  task automatic clear_mon();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    done_cnt = 0;
    done_cyc = -1;
  endtask

  task automatic set_cfg(input int n_in, input int n_out, input int relu, input int izp,
                         input int fzp, input int ozp, input int mult, input int shift);
    i_n_in        = IN_AW'(n_in);
    i_n_out       = OUT_AW'(n_out);
    i_relu_en     = (relu != 0);
    i_input_zp    = 8'(izp);
    i_filter_zp   = 8'(fzp);
    i_output_zp   = 8'(ozp);
    i_quant_mult  = 32'(mult);
    i_quant_shift = 5'(shift);
  endtask

  task automatic load_vec(input vec_t v);
    for (int k = 0; k < 4; k++) in_mem[k] = 8'(v.in_v[k]);
    for (int k = 0; k < 8; k++) w_mem[k]  = 8'(v.w_v[k]);
    for (int k = 0; k < 2; k++) b_mem[k]  = 32'(v.b_v[k]);
    set_cfg(v.n_in, v.n_out, v.relu, v.izp, v.fzp, v.ozp, v.mult, v.shift);
  endtask

  // Pulse start, optionally re-pulse it at two relative cycles, and wait for
  // o_done within a cycle budget.
  task automatic do_run(input string tag, input int budget, input int poke_a, input int poke_b);
    bit ok;
    @(negedge i_clk);
    clear_mon();
    check({tag, " idle_before"}, o_busy, 0);
    t0 = cyc;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    check({tag, " busy_in_load"}, o_busy, 1);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge i_clk);
      i_start = ((cyc - t0) == poke_a) || ((cyc - t0) == poke_b);
      if (done_cnt > 0) ok = 1'b1;
    end
    check({tag, " done_seen"}, ok, 1);
    @(negedge i_clk);
    i_start = 1'b0;
    check({tag, " idle_after"}, o_busy, 0);
    @(negedge i_clk);
    check({tag, " done_once"}, done_cnt, 1);
    check({tag, " still_idle"}, o_busy, 0);
  endtask

  task automatic run_vec(input vec_t v, input string tag, input int poke_a, input int poke_b);
    int n_exp;
    int e;
    load_vec(v);
    do_run(tag, v.done_at + 20, poke_a, poke_b);
    n_exp = (v.n_in == 0 || v.n_out == 0) ? 0 : v.n_out;
    check({tag, " wr_count"}, wr_addr_q.size(), n_exp);
    check({tag, " done_cycle"}, done_cyc, v.done_at);
    for (int j = 0; j < n_exp && j < wr_addr_q.size(); j++) begin
`ifdef DENSE_SAT_EN
      e = v.exp_sat[j];
`else
      e = v.exp_v[j];
`endif
      check($sformatf("%s wr_addr[%0d]", tag, j), wr_addr_q[j], j);
      check($sformatf("%s wr_data[%0d]", tag, j), wr_data_q[j], e);
      check($sformatf("%s wr_cycle[%0d]", tag, j), wr_cyc_q[j], v.first_wr + j * (v.n_in + 5));
    end
  endtask

  // Reference neuron for the larger layer, computed straight from the
  // arithmetic definition with native integer types.
  function automatic int model_out(input int j, input int n, input int izp, input int fzp,
                                   input int ozp, input int relu, input int mult,
                                   input int shift, input int bias);
    int acc;
    int ts;
    longint p;
    longint s;
    logic signed [15:0] y16;
    acc = 0;
    for (int k = 0; k < n; k++)
      acc += (int'($signed(in_mem[k])) - izp) * (int'($signed(w_mem[j * n + k])) - fzp);
    acc += bias;
    if (relu != 0 && acc < 0) acc = 0;
    ts = 31 - shift;
    p = longint'(acc) * longint'(mult) + (longint'(1) << (ts - 1));
    s = p >>> ts;
    y16 = 16'(s) + 16'(ozp);
`ifdef DENSE_SAT_EN
    if (y16 > 16'sd127) return 127;
    if (y16 < -16'sd128) return 128;
`endif
    return int'(y16[7:0]);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bias_v[6];
    int e;

    vecs[0] = '{n_in:2, n_out:1, relu:1, izp:1, fzp:0, ozp:-128, mult:32'h40000000, shift:0,
                in_v:'{3, 5, 0, 0}, w_v:'{2, -1, 0, 0, 0, 0, 0, 0}, b_v:'{10, 0},
                exp_v:'{8'h85, 0}, exp_sat:'{8'h85, 0}, done_at:9, first_wr:8};
    vecs[1] = '{n_in:2, n_out:1, relu:1, izp:1, fzp:0, ozp:0, mult:32'h40000000, shift:0,
                in_v:'{3, 5, 0, 0}, w_v:'{2, -1, 0, 0, 0, 0, 0, 0}, b_v:'{-100, 0},
                exp_v:'{8'h00, 0}, exp_sat:'{8'h00, 0}, done_at:9, first_wr:8};
    vecs[2] = '{n_in:2, n_out:1, relu:0, izp:1, fzp:0, ozp:0, mult:32'h40000000, shift:0,
                in_v:'{3, 5, 0, 0}, w_v:'{2, -1, 0, 0, 0, 0, 0, 0}, b_v:'{-100, 0},
                exp_v:'{8'hCE, 0}, exp_sat:'{8'hCE, 0}, done_at:9, first_wr:8};
    vecs[3] = '{n_in:1, n_out:1, relu:0, izp:0, fzp:0, ozp:0, mult:32'h40000000, shift:0,
                in_v:'{0, 0, 0, 0}, w_v:'{0, 0, 0, 0, 0, 0, 0, 0}, b_v:'{1000, 0},
                exp_v:'{8'hF4, 0}, exp_sat:'{8'h7F, 0}, done_at:8, first_wr:7};
    vecs[4] = '{n_in:3, n_out:2, relu:0, izp:2, fzp:-1, ozp:3, mult:32'h20000000, shift:2,
                in_v:'{10, -20, 7, 0}, w_v:'{1, 2, 3, -4, 5, -6, 0, 0}, b_v:'{100, 50},
                exp_v:'{8'h49, 8'h80}, exp_sat:'{8'h49, 8'h80}, done_at:18, first_wr:9};
    vecs[5] = '{n_in:1, n_out:1, relu:1, izp:0, fzp:0, ozp:-1, mult:32'h60000000, shift:1,
                in_v:'{1, 0, 0, 0}, w_v:'{7, 0, 0, 0, 0, 0, 0, 0}, b_v:'{-2, 0},
                exp_v:'{8'h07, 0}, exp_sat:'{8'h07, 0}, done_at:8, first_wr:7};
    vecs[6] = '{n_in:2, n_out:1, relu:0, izp:-128, fzp:127, ozp:0, mult:1, shift:15,
                in_v:'{-128, 127, 0, 0}, w_v:'{127, -128, 0, 0, 0, 0, 0, 0}, b_v:'{0, 0},
                exp_v:'{8'hFF, 0}, exp_sat:'{8'hFF, 0}, done_at:9, first_wr:8};
    vecs[7] = '{n_in:0, n_out:3, relu:0, izp:0, fzp:0, ozp:0, mult:32'h40000000, shift:0,
                in_v:'{0, 0, 0, 0}, w_v:'{0, 0, 0, 0, 0, 0, 0, 0}, b_v:'{0, 0},
                exp_v:'{0, 0}, exp_sat:'{0, 0}, done_at:2, first_wr:0};
    vecs[8] = '{n_in:4, n_out:0, relu:0, izp:0, fzp:0, ozp:0, mult:32'h40000000, shift:0,
                in_v:'{1, 2, 3, 4}, w_v:'{1, 1, 1, 1, 0, 0, 0, 0}, b_v:'{5, 0},
                exp_v:'{0, 0}, exp_sat:'{0, 0}, done_at:2, first_wr:0};

    for (int i = 0; i < 1024; i++) begin
      in_mem[i] = '0;
      b_mem[i]  = '0;
    end
    for (int i = 0; i < 4096; i++) w_mem[i] = '0;

    i_rst   = 1'b1;
    i_start = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
    clear_mon();
    repeat (3) @(negedge i_clk);
    check("reset ctl_outputs", {o_busy, o_done, o_out_we, o_out_addr, o_out_data, o_in_addr}, 0);
    check("reset addr_outputs", {o_w_addr, o_b_addr}, 0);
    check("reset mul_outputs", {o_mul_a, o_mul_b}, 0);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("after_reset idle", {o_busy, o_done, o_out_we}, 0);

    // Directed vectors.
    for (int v = 0; v < 9; v++) run_vec(vecs[v], $sformatf("vec%0d", v), -1, -1);

    // Start pulsed mid-MAC and again in the DONE cycle: both ignored.
    run_vec(vecs[4], "start_poke", 4, 18);

    // Reset asserted in the middle of MAC, then a clean rerun.
    load_vec(vecs[4]);
    @(negedge i_clk);
    clear_mon();
    t0 = cyc;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (2) @(negedge i_clk);
    check("midrst busy_in_mac", o_busy, 1);
    i_rst = 1'b1;
    #1;
    check("midrst ctl_outputs", {o_busy, o_done, o_out_we, o_out_addr, o_out_data, o_in_addr}, 0);
    check("midrst addr_outputs", {o_w_addr, o_b_addr}, 0);
    check("midrst mul_outputs", {o_mul_a, o_mul_b}, 0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    repeat (25) @(negedge i_clk);
    check("midrst no_writes", wr_addr_q.size(), 0);
    check("midrst no_done", done_cnt, 0);
    check("midrst idle", o_busy, 0);
    run_vec(vecs[4], "after_rst", -1, -1);

    // Larger layer (20 inputs x 6 neurons) against the reference neuron.
    for (int k = 0; k < 20; k++) in_mem[k] = 8'((k * 37 + 5) & 255);
    for (int k = 0; k < 120; k++) w_mem[k] = 8'(((k * 53) ^ 29) & 255);
    for (int j = 0; j < 6; j++) begin
      bias_v[j] = j * 1000 - 2500;
      b_mem[j]  = 32'(bias_v[j]);
    end
    set_cfg(20, 6, 1, -3, 2, 5, 4200, 8);
    do_run("layer20x6", 200, -1, -1);
    check("layer20x6 wr_count", wr_addr_q.size(), 6);
    check("layer20x6 done_cycle", done_cyc, 2 + 6 * 25);
    for (int j = 0; j < 6 && j < wr_addr_q.size(); j++) begin
      e = model_out(j, 20, -3, 2, 5, 1, 4200, 8, bias_v[j]);
      check($sformatf("layer20x6 wr_addr[%0d]", j), wr_addr_q[j], j);
      check($sformatf("layer20x6 wr_data[%0d]", j), wr_data_q[j], e);
      check($sformatf("layer20x6 wr_cycle[%0d]", j), wr_cyc_q[j], 1 + (j + 1) * 25);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
